// File: rtl/sr_sched_pkg.sv
// Shared definitions for the SR latch write sequencer: state encoding,
// operation codes and constant-evaluable sizing helpers.
package sr_sched_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_PULSE = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    SETUP = ST_SETUP,
    PULSE = ST_PULSE,
    HOLD  = ST_HOLD,
    DONE  = ST_DONE
  } state_t;

  localparam logic OP_SET = 1'b1;
  localparam logic OP_CLR = 1'b0;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sr_latch_scheduler_if.sv
// Requester-side bundle: per-requester request/op/index in, grant/ack/status out.
interface sr_latch_scheduler_if #(
  parameter int N_REQ = 4,
  parameter int IW    = 3
);
  logic [N_REQ-1:0]    req;
  logic [N_REQ-1:0]    op;
  logic [N_REQ*IW-1:0] idx;
  logic [N_REQ-1:0]    gnt;
  logic [N_REQ-1:0]    ack;
  logic                err;
  logic                busy;

  modport master (output req, op, idx, input gnt, ack, err, busy);
  modport slave  (input req, op, idx, output gnt, ack, err, busy);
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the search starts one past last_grant,
// done by rotating the request vector, isolating the lowest bit, rotating back.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int LW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [LW-1:0]    last_grant,
  output logic [N_REQ-1:0] grant
);
  logic [LW:0]        sh;
  logic [2*N_REQ-1:0] dbl, back;
  logic [N_REQ-1:0]   rot, pick;

  always_comb begin
    sh    = {1'b0, last_grant} + 1'b1;
    dbl   = {req, req} >> sh;
    rot   = dbl[N_REQ-1:0];
    pick  = rot & (~rot + 1'b1);
    back  = {{N_REQ{1'b0}}, pick} << sh;
    grant = back[N_REQ-1:0] | back[2*N_REQ-1:N_REQ];
  end
endmodule

// File: rtl/sr_latch_scheduler.sv
// Shares a bank of gated SR latches among requesters: each write is
// S/R setup, gate pulse, S/R hold, then a readback-checked acknowledge.
module sr_latch_scheduler
  import sr_sched_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int N_LATCH   = 8,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  sr_latch_scheduler_if.slave bus,
  output logic [N_LATCH-1:0] latch_s,
  output logic [N_LATCH-1:0] latch_r,
  output logic [N_LATCH-1:0] latch_en,
  input  logic [N_LATCH-1:0] latch_q
);
  localparam int IW   = (clog2(N_LATCH) > 1) ? clog2(N_LATCH) : 1;
  localparam int LW   = (clog2(N_REQ) > 1) ? clog2(N_REQ) : 1;
  localparam int MAXC = imax(imax(SETUP_CYC, PULSE_CYC), HOLD_CYC);
  localparam int CW   = (clog2(MAXC + 1) > 1) ? clog2(MAXC + 1) : 1;

  state_t             state, state_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic [LW-1:0]      last_grant, last_grant_n, gnt_num;
  logic               cur_op, cur_op_n, cur_oor, cur_oor_n;
  logic [IW-1:0]      cur_idx, cur_idx_n;
  logic [N_REQ-1:0]   gnt_r, gnt_n, ack_r, ack_n, arb_gnt;
  logic [N_LATCH-1:0] s_n, r_n, en_n, win_sel, cur_sel;
  logic               win_op, win_oor, q_cur;
  logic [IW-1:0]      win_idx;

  rr_arbiter #(.N_REQ(N_REQ), .LW(LW)) u_arb (
    .req       (bus.req),
    .last_grant(last_grant),
    .grant     (arb_gnt)
  );

  always_comb begin
    win_op  = 1'b0;
    win_idx = '0;
    gnt_num = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_gnt[i]) begin
        win_op  = bus.op[i];
        win_idx = bus.idx[i*IW +: IW];
      end
      if (gnt_r[i]) gnt_num = LW'(i);
    end
  end

  // Decoded selects keep every latch-side bit a plain register with no
  // variable-index write; an out-of-range index decodes to no latch at all.
  always_comb begin
    win_sel = '0;
    cur_sel = '0;
    for (int i = 0; i < N_LATCH; i++) begin
      win_sel[i] = (win_idx == IW'(i));
      cur_sel[i] = (cur_idx == IW'(i));
    end
  end

  assign win_oor = 32'(win_idx) >= 32'(N_LATCH);
  assign q_cur   = |(latch_q & cur_sel);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= LW'(N_REQ - 1);
      cur_op     <= 1'b0;
      cur_idx    <= '0;
      cur_oor    <= 1'b0;
      gnt_r      <= '0;
      ack_r      <= '0;
      latch_s    <= '0;
      latch_r    <= '0;
      latch_en   <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      last_grant <= last_grant_n;
      cur_op     <= cur_op_n;
      cur_idx    <= cur_idx_n;
      cur_oor    <= cur_oor_n;
      gnt_r      <= gnt_n;
      ack_r      <= ack_n;
      latch_s    <= s_n;
      latch_r    <= r_n;
      latch_en   <= en_n;
    end
  end

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    last_grant_n = last_grant;
    cur_op_n     = cur_op;
    cur_idx_n    = cur_idx;
    cur_oor_n    = cur_oor;
    gnt_n        = gnt_r;
    ack_n        = '0;
    s_n          = latch_s;
    r_n          = latch_r;
    en_n         = '0;
    unique case (state)
      IDLE: if (|bus.req) begin
        gnt_n     = arb_gnt;
        cur_op_n  = win_op;
        cur_idx_n = win_idx;
        cur_oor_n = win_oor;
        if (win_oor) begin
          state_n = DONE;
          ack_n   = arb_gnt;
        end else begin
          state_n = SETUP;
          cnt_n   = CW'(SETUP_CYC - 1);
          s_n     = (win_op == OP_SET) ? win_sel : '0;
          r_n     = (win_op == OP_CLR) ? win_sel : '0;
        end
      end
      SETUP: if (cnt == '0) begin
        state_n = PULSE;
        cnt_n   = CW'(PULSE_CYC - 1);
        en_n    = cur_sel;
      end else cnt_n = cnt - 1'b1;
      PULSE: if (cnt == '0) begin
        state_n = HOLD;
        cnt_n   = CW'(HOLD_CYC - 1);
      end else begin
        cnt_n = cnt - 1'b1;
        en_n  = cur_sel;
      end
      // S/R only drop on the way into DONE, HOLD_CYC cycles after the gate fell.
      HOLD: if (cnt == '0) begin
        state_n = DONE;
        cnt_n   = '0;
        ack_n   = gnt_r;
        s_n     = '0;
        r_n     = '0;
      end else cnt_n = cnt - 1'b1;
      DONE: begin
        state_n      = IDLE;
        gnt_n        = '0;
        last_grant_n = gnt_num;
      end
      default: state_n = IDLE;
    endcase
  end

  // Readback is taken straight from Q during DONE so it reflects the settled latch.
  assign bus.gnt  = gnt_r;
  assign bus.ack  = ack_r;
  assign bus.busy = (state != IDLE);
  assign bus.err  = (|ack_r) & (cur_oor | (q_cur != cur_op));

endmodule

// File: doc/sr_latch_scheduler.md
# sr_latch_scheduler

Sequencer and round-robin arbiter that shares a bank of gated SR latches among several requesters. It turns each set/clear request into a safe write: S/R setup, gate pulse, S/R hold. It then reads back the latch output and acknowledges. It sits between control logic and the latch bank; each latch's S, R and gate (CLK) pins connect only to this block.

## Interface
- N_REQ, 4: number of requesters (≥2)
- N_LATCH, 8: number of latches in the bank (≥1)
- SETUP_CYC, 1: cycles S/R are stable before the gate rises (≥1)
- PULSE_CYC, 2: gate high time in cycles (≥1)
- HOLD_CYC, 1: cycles S/R are held after the gate falls (≥1)
- CLK  in  1  single clock, rising edge
- RST_N  in  1  asynchronous, active-low reset
- REQ  in  N_REQ  per-requester request level
- OP  in  N_REQ  per-requester operation, 1 = set, 0 = clear
- IDX  in  N_REQ*IW  per-requester latch index, flattened, requester i at [i*IW +: IW], IW = max(1, clog2(N_LATCH))
- GNT  out  N_REQ  one-hot, high for the granted requester from SETUP through DONE
- ACK  out  N_REQ  one-cycle completion pulse to the granted requester
- ERR  out  1  one-cycle pulse coincident with ACK when the write failed
- BUSY  out  1  high in any state other than IDLE
- LATCH_S  out  N_LATCH  S input per latch
- LATCH_R  out  N_LATCH  R input per latch
- LATCH_EN  out  N_LATCH  gate (CLK) input per latch
- LATCH_Q  in  N_LATCH  Q output per latch, used for readback

## Operation
- FSM states: IDLE, SETUP, PULSE, HOLD, DONE. A down-counter times SETUP, PULSE and HOLD.
- IDLE: if any REQ is high, the arbiter picks a winner round-robin, starting at last_grant+1.
  - The winner's OP and IDX are captured in registers.
  - GNT is set, the counter is loaded with SETUP_CYC-1, and the FSM goes to SETUP.
- Index out of range (IDX ≥ N_LATCH): go IDLE→DONE directly. No S/R/EN activity. ERR is asserted with ACK.
- SETUP: LATCH_S[idx] = OP and LATCH_R[idx] = ~OP. All other S/R bits are 0 and all EN bits are 0.
- PULSE: LATCH_EN[idx] = 1 and S/R are unchanged.
- HOLD: EN is 0 and S/R are unchanged.
- DONE:
  - ACK[grant] = 1. ERR = (LATCH_Q[idx] != OP).
  - S/R/EN are all 0 and GNT is cleared on exit.
  - last_grant is updated and the FSM returns to IDLE.
- Invariants:
  - LATCH_S & LATCH_R == 0 at all times.
  - At most one LATCH_EN bit is high.
  - No EN bit is ever high while its S/R are changing.
  - All latch-side outputs are registered, with no combinational path from REQ.
- Captured OP/IDX are used for the whole transaction. REQ dropping after the grant does not abort it; ACK still pulses.
- A requester holding REQ high after ACK issues a new request. Round-robin guarantees other pending requesters are served first.

## Timing
- Reset: all outputs 0, FSM in IDLE, last_grant = N_REQ-1 (requester 0 has first priority), counter 0.
- Reset mid-transaction clears EN immediately. The latch retains its current state, no ACK is issued, and the request is lost.
- Requests are sampled at edge e0 in IDLE. SETUP starts after e0, PULSE after e0+SETUP_CYC, HOLD after e0+SETUP_CYC+PULSE_CYC, DONE after e0+SETUP_CYC+PULSE_CYC+HOLD_CYC.
- ACK and ERR are high for exactly one cycle following edge e0+SETUP_CYC+PULSE_CYC+HOLD_CYC. With defaults this is edge e0+4.
- Throughput: 2+SETUP_CYC+PULSE_CYC+HOLD_CYC cycles per write, including the IDLE cycle. The default is 6.
- LATCH_Q is sampled at the rising edge ending the DONE cycle. It is valid because EN fell at least HOLD_CYC cycles earlier.
- Out-of-range writes take 2 cycles: IDLE then DONE.
- Counter width is clog2(max(SETUP_CYC, PULSE_CYC, HOLD_CYC)+1).

## Structure
- Shared package/include sr_sched_pkg holds:
  - state encoding localparams
  - OP_SET=1 and OP_CLR=0
  - a clog2 function
- Sub-module rr_arbiter: N_REQ-wide, with inputs req and last_grant and a one-hot grant output. It is purely combinational, and last_grant is registered in the parent.

## Test plan
- Single set, defaults: REQ[0]=1, OP=1, IDX=3 at e0. LATCH_S[3] is high for 4 cycles, EN[3] is high in the cycles after e0+1 and e0+2, then ACK[0] pulses after e0+4 with ERR=0 (model Q[3]=1).
- Fairness: REQ=4'b1111 held for 8 transactions gives GNT order 0,1,2,3,0,1,2,3, with each ACK 6 cycles apart.
- Readback failure: clear IDX=5 with model Q[5] stuck at 1 gives ACK with ERR=1. No other latch toggles.
- Out of range: N_LATCH=6, IDX=7 gives ACK plus ERR two cycles after the request. LATCH_S/R/EN stay 0.
- Reset mid-PULSE: assert RST_N=0 in the first PULSE cycle. EN drops asynchronously, there is no ACK, BUSY=0, and after release requester 0 is granted first.
- Invariant monitor across random REQ/OP/IDX traffic with REQ withdrawn after grant: S&R is never nonzero, EN is never multi-hot, and every grant gets exactly one ACK.
